cm0_clk_en_ctl: RTL and testbench

//  Parametrised clock-enable controller for the always-on clock-gate level.

---
 rtl/cm0_clk_en_ctl.sv | 98 +++++++++
 tb/tb_cm0_clk_en_ctl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cm0_clk_en_ctl.sv
// Always-on clock-enable controller: per-channel idle hysteresis plus a
// sleep handshake that holds SLEEP_MASK channels off while asleep.
module cm0_clk_en_ctl #(
  parameter int unsigned    NCH        = 3,
  parameter int unsigned    HYST       = 4,
  parameter bit             ACG        = 1'b1,
  parameter logic [NCH-1:0] SLEEP_MASK = '1
) (
  input  logic           hclk,
  input  logic           hreset_n,
  input  logic           SE,
  input  logic [NCH-1:0] req_en_i,
  input  logic [NCH-1:0] force_on_i,
  input  logic           sleep_req_i,
  input  logic           wake_i,
  output logic [NCH-1:0] clk_en_o,
  output logic           sleep_ack_o,
  output logic           idle_o
);

  localparam logic [3:0] HYST_V = 4'(HYST);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_t;

  state_t         state;
  logic [3:0]     cnt [NCH];
  logic [NCH-1:0] active;
  logic [NCH-1:0] wanted;
  logic [NCH-1:0] gate_ok;
  logic           drain_done;
  logic           all_quiet;
  logic           leave_sleep;
  logic           wake_load;

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < NCH; i++) active[i] = (cnt[i] != 4'd0);
  end

  assign wanted      = req_en_i | force_on_i;
  assign drain_done  = ((active | req_en_i) & SLEEP_MASK) == '0;
  assign all_quiet   = (active | wanted) == '0;
  assign leave_sleep = !sleep_req_i || wake_i;
  assign wake_load   = (state == SLEEP) && leave_sleep;
  assign gate_ok     = (state == SLEEP) ? ~SLEEP_MASK : '1;

  // Request path stays combinational so a request enables its clock in the same cycle.
  assign clk_en_o = {NCH{SE || !ACG}} | force_on_i | (gate_ok & (req_en_i | active));

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      for (int unsigned i = 0; i < NCH; i++) cnt[i] <= HYST_V;
    end else if (ACG) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (wake_load || wanted[i]) cnt[i] <= HYST_V;
        else if (active[i])         cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state       <= RUN;
      sleep_ack_o <= 1'b0;
    end else if (ACG) begin
      case (state)
        RUN:   if (sleep_req_i) state <= DRAIN;
        DRAIN: begin
          if (leave_sleep) begin
            state <= RUN;
          end else if (drain_done) begin
            state       <= SLEEP;
            sleep_ack_o <= 1'b1;
          end
        end
        SLEEP: begin
          if (leave_sleep) begin
            state       <= WAKE;
            sleep_ack_o <= 1'b0;
          end
        end
        WAKE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) idle_o <= 1'b0;
    else           idle_o <= all_quiet;
  end

endmodule

// File: tb/tb_cm0_clk_en_ctl.sv
// Scoreboard bench for cm0_clk_en_ctl: a timestamp-based reference model queues
// expected outputs per cycle, a monitor compares them on the falling edge.
module tb_cm0_clk_en_ctl;

  localparam int unsigned NCH  = 3;
  localparam int          HYST = 4;
  localparam logic [2:0]  MASK = 3'b111;

  logic       hclk = 1'b0;
  logic       hreset_n = 1'b0;
  logic       se = 1'b0;
  logic       sleep_req = 1'b0;
  logic       wake = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] frc = '0;
  logic [2:0] en, nog_en;
  logic       ack, idle, nog_ack, nog_idle;

  always #5 hclk = ~hclk;

  cm0_clk_en_ctl #(.NCH(NCH), .HYST(HYST), .ACG(1'b1), .SLEEP_MASK(MASK)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .SE(se), .req_en_i(req), .force_on_i(frc),
    .sleep_req_i(sleep_req), .wake_i(wake), .clk_en_o(en), .sleep_ack_o(ack), .idle_o(idle)
  );

  cm0_clk_en_ctl #(.NCH(NCH), .HYST(HYST), .ACG(1'b0), .SLEEP_MASK(MASK)) dut_nog (
    .hclk(hclk), .hreset_n(hreset_n), .SE(se), .req_en_i(req), .force_on_i(frc),
    .sleep_req_i(sleep_req), .wake_i(wake), .clk_en_o(nog_en), .sleep_ack_o(nog_ack),
    .idle_o(nog_idle)
  );

  typedef struct {
    logic [2:0] en;
    logic       ack;
    logic       idle;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;

  // Model: each channel remembers the last cycle through which its hysteresis holds it on.
  int hold[NCH];
  bit m_drain, m_sleep, m_wake, m_idle;

  function automatic void model_reset();
    for (int i = 0; i < int'(NCH); i++) hold[i] = cyc + HYST - 1;
    m_drain = 0; m_sleep = 0; m_wake = 0; m_idle = 0;
  endfunction

  function automatic logic [2:0] model_en();
    logic [2:0] e;
    bit act, gated;
    e = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      act   = (cyc <= hold[i]);
      gated = m_sleep && MASK[i];
      e[i]  = se | frc[i] | (!gated & (req[i] | act));
    end
    return e;
  endfunction

  function automatic void model_edge();
    bit quiet, dok, leave, act;
    quiet = 1; dok = 1;
    leave = !sleep_req || wake;
    for (int i = 0; i < int'(NCH); i++) begin
      act = (cyc <= hold[i]);
      if (act || req[i] || frc[i]) quiet = 0;
      if (MASK[i] && (act || req[i])) dok = 0;
    end
    m_idle = quiet;
    for (int i = 0; i < int'(NCH); i++) if (req[i] || frc[i]) hold[i] = cyc + HYST;
    if (m_sleep) begin
      if (leave) begin
        for (int i = 0; i < int'(NCH); i++) hold[i] = cyc + HYST;
        m_sleep = 0; m_wake = 1;
      end
    end else if (m_wake) begin
      m_wake = 0;
    end else if (m_drain) begin
      if (leave) m_drain = 0;
      else if (dok) begin m_drain = 0; m_sleep = 1; end
    end else if (sleep_req) begin
      m_drain = 1;
    end
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic step(input logic [2:0] r, input logic [2:0] f, input logic sr,
                      input logic wk, input logic s);
    exp_t e;
    req = r; frc = f; sleep_req = sr; wake = wk; se = s;
    e.en   = model_en();
    e.ack  = m_sleep;
    e.idle = m_idle;
    sb.push_back(e);
    @(posedge hclk);
    model_edge();
    cyc++;
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("clk_en",   8'(en),       8'(e.en));
        check("sleep_ack", 8'(ack),     8'(e.ack));
        check("idle",     8'(idle),     8'(e.idle));
        check("nog_en",   8'(nog_en),   8'(3'b111));
        check("nog_ack",  8'(nog_ack),  8'(1'b0));
        check("nog_idle", 8'(nog_idle), 8'(1'b0));
      end
    end
  end

  initial begin
    logic       sr;
    logic [2:0] r, f;
    int         lvl;
    repeat (3) @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    model_reset();

    repeat (7) step(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    step(3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
    repeat (2) step(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    step(3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
    repeat (6) step(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    repeat (3) step(3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
    repeat (8) step(3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    repeat (2) step(3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
    repeat (2) step(3'b000, 3'b100, 1'b1, 1'b0, 1'b0);
    repeat (2) step(3'b011, 3'b000, 1'b1, 1'b0, 1'b1);

    step(3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
    repeat (6) step(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    repeat (8) step(3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    check("ack_before_reset", 8'(ack), 8'(m_sleep));
    hreset_n = 1'b0;
    #1;
    check("ack_async_reset", 8'(ack), 8'(1'b0));
    check("en_in_reset", 8'(en), 8'(3'b111));
    @(posedge hclk);
    @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    model_reset();

    sr = 1'b0;
    lvl = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 24 == 0) lvl = $urandom_range(0, 2);
      if ($urandom_range(0, 19) == 0) sr = ~sr;
      r = (lvl == 0) ? 3'b000 : (lvl == 1) ? (3'($urandom) & 3'($urandom) & 3'($urandom))
                                            : 3'($urandom);
      f = ($urandom_range(0, 31) == 0) ? 3'($urandom) : 3'b000;
      step(r, f, sr, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    repeat (2) @(negedge hclk);
    check("sb_drained", 8'(sb.size()), 8'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
